// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard unit with a private EX..WB tag pipeline.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_scoreboard #(
  parameter int RSIZE    = 3,
  parameter int NRD      = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_STG = 2,
  localparam int SW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NRD*RSIZE-1:0] id_raddr,
  input  logic [RSIZE-1:0]     id_waddr,
  input  logic                 id_wen,
  input  logic                 id_load,
  input  logic                 pipe_hold,
  input  logic                 ex_flush,
  output logic                 stall,
  output logic [NRD*SW-1:0]    ex_fwd_sel,
  output logic [31:0]          stall_cnt
);

  typedef struct packed {
    logic             v;
    logic [RSIZE-1:0] waddr;
    logic             load;
  } tag_t;

  tag_t tag_q [DEPTH];
  tag_t tag_d [DEPTH];

  logic [NRD*SW-1:0] fwd_q;
  logic [NRD*SW-1:0] fwd_d;
  logic [NRD*SW-1:0] sel_c;
  logic [NRD-1:0]    need_stall;
  logic [RSIZE-1:0]  raddr;
  logic              found;
  logic              id_go;

  // Scan youngest stage first; the first hit decides the port.
  always_comb begin
    sel_c      = '0;
    need_stall = '0;
    raddr      = '0;
    found      = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      raddr = id_raddr[p*RSIZE +: RSIZE];
      found = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        if (!found && tag_q[s].v &&
            tag_q[s].waddr == raddr &&
            raddr != '0) begin
          found = 1'b1;
          if (tag_q[s].load && (s + 1 < LOAD_STG)) begin
            need_stall[p] = 1'b1;
          end else if (s + 1 <= DEPTH - 1) begin
            sel_c[p*SW +: SW] = SW'(s + 1);
          end
        end
      end
    end
  end

  assign stall = id_valid && !ex_flush && (|need_stall);
  assign id_go = id_valid && !stall && !ex_flush;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      tag_d[k] = tag_q[k];
    end
    fwd_d = fwd_q;
    if (!pipe_hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        tag_d[k] = tag_q[k-1];
      end
      if (ex_flush) begin
        tag_d[1] = '0;
      end
      tag_d[0] = '0;
      if (id_go && id_wen && id_waddr != '0) begin
        tag_d[0] = '{v: 1'b1, waddr: id_waddr, load: id_load};
      end
      fwd_d = id_go ? sel_c : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
      fwd_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
      fwd_q <= fwd_d;
    end
  end

  assign ex_fwd_sel = fwd_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !pipe_hold && cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with default parameters.
// Port p sel is ex_fwd_sel[2p+1:2p]; raddr port p is id_raddr[3p+2:3p].
module tb_fwd_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_raddr;
  logic [2:0]  id_waddr;
  logic        id_wen;
  logic        id_load;
  logic        pipe_hold;
  logic        ex_flush;
  logic        stall;
  logic [3:0]  ex_fwd_sel;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef FWD_STALL_CNT_EN
  localparam logic [31:0] CNT1 = 32'd1;
`else
  localparam logic [31:0] CNT1 = 32'd0;
`endif

  fwd_hazard_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_raddr   (id_raddr),
    .id_waddr   (id_waddr),
    .id_wen     (id_wen),
    .id_load    (id_load),
    .pipe_hold  (pipe_hold),
    .ex_flush   (ex_flush),
    .stall      (stall),
    .ex_fwd_sel (ex_fwd_sel),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wen,
                       input logic [2:0] wa, input logic ld,
                       input logic [2:0] r0, input logic [2:0] r1);
    id_valid = v;
    id_wen   = wen;
    id_waddr = wa;
    id_load  = ld;
    id_raddr = {r1, r0};
    #1;
  endtask

  task automatic do_reset;
    pipe_hold = 1'b0;
    ex_flush  = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    pipe_hold = 1'b0;
    ex_flush  = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_sel got %b want 0000", ex_fwd_sel);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_stall got %b want 0", stall);
    end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_cnt got %0d want 0", stall_cnt);
    end
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_fwd_ex;
    do_reset;
    drive(1, 1, 3, 0, 0, 0);
    tick;
    drive(1, 0, 0, 0, 3, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL ex_stall got %b want 0", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0001) begin
      n_bad++;
      $display("FAIL ex_sel got %b want 0001", ex_fwd_sel);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fwd_mem;
    do_reset;
    drive(1, 1, 3, 0, 0, 0);
    tick;
    drive(1, 1, 6, 0, 1, 2);
    tick;
    drive(1, 0, 0, 0, 0, 3);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL mem_stall got %b want 0", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b1000) begin
      n_bad++;
      $display("FAIL mem_sel got %b want 1000", ex_fwd_sel);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wb_stage;
    do_reset;
    drive(1, 1, 3, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    tick;
    drive(1, 0, 0, 0, 3, 3);
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL wb_sel got %b want 0000", ex_fwd_sel);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use;
    do_reset;
    drive(1, 1, 5, 1, 0, 0);
    tick;
    drive(1, 0, 0, 0, 5, 0);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_stall1 got %b want 1", stall);
    end
    tick;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_stall2 got %b want 0", stall);
    end
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL lu_bubble got %b want 0000", ex_fwd_sel);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0010) begin
      n_bad++;
      $display("FAIL lu_sel got %b want 0010", ex_fwd_sel);
    end
    n_cmp++;
    if (stall_cnt !== CNT1) begin
      n_bad++;
      $display("FAIL lu_cnt got %0d want %0d", stall_cnt, CNT1);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_youngest_r0;
    do_reset;
    drive(1, 1, 4, 0, 0, 0);
    tick;
    drive(1, 1, 4, 0, 0, 0);
    tick;
    drive(1, 0, 0, 0, 4, 4);
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0101) begin
      n_bad++;
      $display("FAIL young_sel got %b want 0101", ex_fwd_sel);
    end
    drive(1, 1, 0, 1, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_stall got %b want 0", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL r0_sel got %b want 0000", ex_fwd_sel);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush;
    do_reset;
    drive(1, 1, 5, 1, 0, 0);
    tick;
    ex_flush = 1'b1;
    drive(1, 0, 0, 0, 5, 0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_stall got %b want 0", stall);
    end
    tick;
    ex_flush = 1'b0;
    drive(1, 0, 0, 0, 5, 5);
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL fl_sel got %b want 0000", ex_fwd_sel);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_after got %b want 0", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL fl_kill got %b want 0000", ex_fwd_sel);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hold;
    do_reset;
    drive(1, 1, 2, 0, 0, 0);
    tick;
    drive(1, 1, 5, 1, 2, 0);
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0001) begin
      n_bad++;
      $display("FAIL hd_pre got %b want 0001", ex_fwd_sel);
    end
    pipe_hold = 1'b1;
    drive(1, 0, 0, 0, 0, 5);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (stall !== 1'b1) begin
        n_bad++;
        $display("FAIL hd_stall%0d got %b want 1", i, stall);
      end
      tick;
      n_cmp++;
      if (ex_fwd_sel !== 4'b0001) begin
        n_bad++;
        $display("FAIL hd_sel%0d got %b want 0001", i, ex_fwd_sel);
      end
    end
    ex_flush = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL hdfl_stall got %b want 0", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0001) begin
      n_bad++;
      $display("FAIL hdfl_sel got %b want 0001", ex_fwd_sel);
    end
    ex_flush  = 1'b0;
    pipe_hold = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL hd_rel got %b want 1", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL hd_bub got %b want 0000", ex_fwd_sel);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL hd_go got %b want 0", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b1000) begin
      n_bad++;
      $display("FAIL hd_sel got %b want 1000", ex_fwd_sel);
    end
    n_cmp++;
    if (stall_cnt !== CNT1) begin
      n_bad++;
      $display("FAIL hd_cnt got %0d want %0d", stall_cnt, CNT1);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    do_reset;
    drive(1, 1, 5, 1, 0, 0);
    tick;
    drive(1, 0, 0, 0, 5, 0);
    tick;
    tick;
    drive(1, 1, 3, 0, 0, 0);
    tick;
    drive(1, 1, 6, 1, 3, 0);
    tick;
    drive(1, 0, 0, 0, 6, 0);
    n_cmp++;
    if (stall !== 1'b1 || ex_fwd_sel !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_pre got %b/%b want 1/0001", stall, ex_fwd_sel);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_sel got %b want 0000", ex_fwd_sel);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_stall got %b want 0", stall);
    end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_cnt got %0d want 0", stall_cnt);
    end
    tick;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 3, 3);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL post_stall got %b want 0", stall);
    end
    tick;
    n_cmp++;
    if (ex_fwd_sel !== 4'b0000) begin
      n_bad++;
      $display("FAIL post_sel got %b want 0000", ex_fwd_sel);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset;
    test_fwd_ex;
    test_fwd_mem;
    test_wb_stage;
    test_load_use;
    test_youngest_r0;
    test_flush;
    test_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
